// File: rtl/jk_bank_controller.sv
// jk_bank_controller: round-robin arbiter driving one WIDTH-bit JK flip-flop bank.
// Readback CHECK state is built only when JK_READBACK_CHECK_EN is defined.
module jk_bank_controller #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a_valid,
  output logic             req_a_ready,
  input  logic [1:0]       req_a_op,
  input  logic [WIDTH-1:0] req_a_mask,
  input  logic             req_b_valid,
  output logic             req_b_ready,
  input  logic [1:0]       req_b_op,
  input  logic [WIDTH-1:0] req_b_mask,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] jk_q,
  output logic             done,
  output logic             done_id,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             err_q, err_d;

  logic             idle;
  logic             win_b;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;

`ifdef JK_READBACK_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d;

  function automatic logic [WIDTH-1:0] predict(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] m,
    input logic [WIDTH-1:0] q
  );
    logic [WIDTH-1:0] r;
    r = q;
    unique case (1'b1)
      (op == 2'b00): r = q;
      (op == 2'b01): r = q & ~m;
      (op == 2'b10): r = q | m;
      (op == 2'b11): r = q ^ m;
    endcase
    return r;
  endfunction
`else
  logic unused_rb;
  assign unused_rb = ^jk_q;
`endif

  // Arbitration: ptr_q=1 means B is favoured when both are valid.
  always_comb begin
    idle        = (state_q == IDLE) & rst_n;
    win_b       = req_b_valid & (~req_a_valid | ptr_q);
    req_a_ready = idle & req_a_valid & ~win_b;
    req_b_ready = idle & win_b;
    accept      = req_a_ready | req_b_ready;
    sel_op      = win_b ? req_b_op : req_a_op;
    sel_mask    = win_b ? req_b_mask : req_a_mask;
  end

  // Next state and registered outputs; J/K are nonzero only in APPLY.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    j_d       = '0;
    k_d       = '0;
    done_d    = 1'b0;
    done_id_d = 1'b0;
    err_d     = 1'b0;
`ifdef JK_READBACK_CHECK_EN
    exp_d     = exp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = APPLY;
          id_d    = win_b;
          ptr_d   = ~win_b;
          j_d     = sel_mask & {WIDTH{sel_op[1]}};
          k_d     = sel_mask & {WIDTH{sel_op[0]}};
`ifdef JK_READBACK_CHECK_EN
          exp_d   = predict(sel_op, sel_mask, jk_q);
`endif
        end
      end
      APPLY: begin
`ifdef JK_READBACK_CHECK_EN
        state_d = CHECK;
`else
        state_d   = DONE;
        done_d    = 1'b1;
        done_id_d = id_q;
`endif
      end
`ifdef JK_READBACK_CHECK_EN
      CHECK: begin
        state_d   = DONE;
        done_d    = 1'b1;
        done_id_d = id_q;
        err_d     = (jk_q != exp_q);
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      j_q       <= '0;
      k_q       <= '0;
      id_q      <= 1'b0;
      ptr_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef JK_READBACK_CHECK_EN
      exp_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      k_q       <= k_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
`ifdef JK_READBACK_CHECK_EN
      exp_q     <= exp_d;
`endif
    end
  end

  assign jk_j    = j_q;
  assign jk_k    = k_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;

endmodule

// File: tb/tb_jk_bank_controller.sv
// tb_jk_bank_controller: random and directed stimulus against a
// command-level model of arbitration, timing and bank contents.
module tb_jk_bank_controller;
  localparam int W = 4;
`ifdef JK_READBACK_CHECK_EN
  localparam int DPH = 2;
`else
  localparam int DPH = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_v, a_rdy, b_v, b_rdy;
  logic [1:0]   a_op, b_op;
  logic [W-1:0] a_m, b_m;
  logic [W-1:0] jk_j, jk_k, jk_q;
  logic         done, done_id, err;

  logic [W-1:0] bq = '0;
  logic [W-1:0] stuck = '0;

  int n_cmp = 0;
  int n_bad = 0;

  bit           busy = 0;
  int           ph = 0;
  int           last = -1;
  bit           m_id, m_err;
  logic [W-1:0] mq = '0;
  logic [W-1:0] m_exp, m_j, m_k;

  jk_bank_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(a_v), .req_a_ready(a_rdy),
    .req_a_op(a_op), .req_a_mask(a_m),
    .req_b_valid(b_v), .req_b_ready(b_rdy),
    .req_b_op(b_op), .req_b_mask(b_m),
    .jk_j(jk_j), .jk_k(jk_k), .jk_q(jk_q),
    .done(done), .done_id(done_id), .err(err)
  );

  always #5 clk = ~clk;

  // Bank of JK flip-flops, with optional stuck-at-0 bits.
  assign jk_q = bq & ~stuck;
  always @(posedge clk) begin
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) begin
      case ({jk_j[i], jk_k[i]})
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        2'b11:   n[i] = ~jk_q[i];
        default: n[i] = jk_q[i];
      endcase
    end
    bq <= n & ~stuck;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic int pick(bit av, bit bv);
    if (av && bv) return (last == 0) ? 1 : 0;
    if (av) return 0;
    if (bv) return 1;
    return -1;
  endfunction

  task automatic check_outputs();
    bit dn;
    dn = busy && (ph == DPH);
    check("jk_j", jk_j, (busy && ph == 0) ? m_j : 4'b0);
    check("jk_k", jk_k, (busy && ph == 0) ? m_k : 4'b0);
    check("jk_q", jk_q, mq);
    check("done", done, dn);
    if (dn) begin
      check("done_id", done_id, m_id);
      check("err", err, m_err);
    end
  endtask

  task automatic step(input bit av, input logic [1:0] aop,
                      input logic [W-1:0] am, input bit bv,
                      input logic [1:0] bop, input logic [W-1:0] bm);
    int w;
    logic [1:0] op;
    logic [W-1:0] m;
    a_v = av; a_op = aop; a_m = am;
    b_v = bv; b_op = bop; b_m = bm;
    #1;
    w = busy ? -1 : pick(av, bv);
    check("rdy_a", a_rdy, w == 0);
    check("rdy_b", b_rdy, w == 1);
    @(posedge clk);
    if (busy) begin
      ph++;
      if (ph == 1) begin
        mq = m_exp & ~stuck;
`ifdef JK_READBACK_CHECK_EN
        m_err = (mq != m_exp);
`else
        m_err = 1'b0;
`endif
      end
      if (ph > DPH) busy = 0;
    end else if (w >= 0) begin
      op = (w == 1) ? bop : aop;
      m  = (w == 1) ? bm : am;
      case (op)
        2'b00: begin m_exp = mq;      m_j = '0; m_k = '0; end
        2'b01: begin m_exp = mq & ~m; m_j = '0; m_k = m;  end
        2'b10: begin m_exp = mq | m;  m_j = m;  m_k = '0; end
        default: begin m_exp = mq ^ m; m_j = m; m_k = m;  end
      endcase
      m_id = (w == 1);
      last = w;
      busy = 1;
      ph   = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, '0, 0, 2'b00, '0);
  endtask

  task automatic reset_dut();
    a_v = 0; b_v = 0;
    rst_n = 1'b0;
    busy = 0; last = -1;
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    a_v = 1; b_v = 1; a_op = 2'b10; b_op = 2'b10;
    a_m = '1; b_m = '1;
    #2;
    check("rst_rdy_a", a_rdy, 1'b0);
    check("rst_rdy_b", b_rdy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_done_id", done_id, 1'b0);
    check_outputs();
    a_v = 0; b_v = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // A SET 0101 from Q=0000
    step(1, 2'b10, 4'b0101, 0, 2'b00, '0);
    idle_steps(4);
    check("t1_q", jk_q, 4'b0101);

    // Both valid after reset: A first, B at next slot
    reset_dut();
    step(1, 2'b11, 4'b1111, 1, 2'b01, 4'b0001);
    for (int i = 0; i < 7; i++) step(0, 2'b00, '0, 1, 2'b01, 4'b0001);
    idle_steps(4);
    check("t2_q", jk_q, 4'b1010);

    // B continuously valid, A idle
    for (int i = 0; i < 20; i++)
      step(0, 2'b00, '0, 1, 2'($urandom_range(3)), 4'($urandom));
    idle_steps(4);

    // Reset during APPLY
    step(1, 2'b10, 4'b1111, 0, 2'b00, '0);
    rst_n = 1'b0;
    busy = 0; last = -1;
    #1;
    check("mid_jk_j", jk_j, 4'b0);
    check("mid_jk_k", jk_k, 4'b0);
    check("mid_done", done, 1'b0);
    check("mid_rdy_a", a_rdy, 1'b0);
    a_v = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    step(1, 2'b00, '0, 1, 2'b10, 4'b0011);
    idle_steps(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(9) < 6, 2'($urandom_range(3)), 4'($urandom),
           $urandom_range(9) < 6, 2'($urandom_range(3)), 4'($urandom));
    idle_steps(4);

    // Bit 0 stuck at 0, then A SET 0001
    stuck = 4'b0001;
    mq = mq & ~stuck;
    step(1, 2'b10, 4'b0001, 0, 2'b00, '0);
    idle_steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
